stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Sequencing controller for the lab stopwatch: owns the run/pause/lap/clear state machine and an MM:SS BCD time counter.
- Inputs are single-cycle button pulses (from the existing debounce/one-pulse chain) and a free-running tick enable.
- Output is a 16-bit BCD display word for the 7-seg scan driver, plus status.
- Replaces ad-hoc toggle FSMs with one block that arbitrates the two buttons.

Parameters:
- TICKS_PER_SEC, 100: tick pulses per second; prescaler counts 0..TICKS_PER_SEC-1.
- PRESC_W, 7: prescaler width; must satisfy 2^PRESC_W >= TICKS_PER_SEC.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- start_stop  input  1  one-cycle pulse; run/pause request.
- lap_reset  input  1  one-cycle pulse; lap freeze/release while running, clear while paused.
- tick  input  1  one-cycle enable pulse at TICKS_PER_SEC Hz.
- state  output  2  current FSM state: IDLE=2'b00, COUNT=2'b01, PAUSE=2'b10, LAP=2'b11.
- running  output  1  high in COUNT or LAP.
- disp  output  16  BCD {min_hi,min_lo,sec_hi,sec_lo} shown to the display.
- wrap  output  1  one-cycle pulse when time rolls 59:59 -> 00:00.

Behaviour:
- Reset: rst sampled on posedge clk only. Outputs after reset: state=IDLE, running=0, disp=16'h0000, wrap=0. Prescaler, live time and lap register are all cleared. A rst mid-count wins over every other input in that cycle.
- Transitions (evaluated on button pulses; start_stop has priority when both pulses arrive in the same cycle):
  - IDLE: start_stop -> COUNT. lap_reset is ignored.
  - COUNT: start_stop -> PAUSE. lap_reset -> LAP, and live time is copied into the lap register in that same edge.
  - LAP: start_stop -> PAUSE (display released). lap_reset -> COUNT (display released).
  - PAUSE: start_stop -> COUNT. lap_reset -> IDLE, clearing prescaler and live time on that edge.
- Prescaler:
  - Advances on tick only in COUNT or LAP.
  - Holds its value in PAUSE, so no partial second is lost.
  - On tick with prescaler == TICKS_PER_SEC-1, it returns to 0 and the seconds advance by one.
- BCD time arithmetic:
  - Each digit is 4 bits and never leaves the range 0-9; sec_hi and min_hi stay in 0-5.
  - sec_lo 9 -> 0 carries into sec_hi; sec 59 -> 00 carries into min.
  - 59:59 -> 00:00 wraps; wrap is asserted for exactly the cycle after the wrapping edge, and counting continues.
- Latency: the time update is registered, so disp reflects a second advance 1 clk after the terminal tick.
- Display select: disp is the lap register in LAP and live time in all other states. Live time keeps counting in LAP.
- Button edge case: a start_stop arriving on the same edge as a terminal tick in COUNT moves to PAUSE and the second increment still occurs.
- running is a combinational decode of the registered state.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined: LAP state, lap register and the freeze behaviour are present, as described above.
- Undefined:
  - The lap register is not built and LAP is unreachable.
  - lap_reset in COUNT is ignored; lap_reset in PAUSE still clears to IDLE.
  - disp is always live time, and state never reports 2'b11.

Decomposition:
- Package stopwatch_pkg: state code constants (IDLE/COUNT/PAUSE/LAP), BCD digit width (4), digit limits (9, 5).
- Sub-module bcd_mmss_counter:
  - Inputs: clk, rst, clr, inc. Outputs: 16-bit BCD time, wrap.
  - Contains the digit chain and carries.
- stopwatch_ctrl keeps the FSM, prescaler, lap register and display mux.

Test Plan:
- Reset/idle: rst held 2 cycles, then lap_reset pulse -> state=00, disp=0000, running=0.
- Count: start_stop, then 3*TICKS_PER_SEC ticks -> state=01, disp=0003 one clk after the 300th tick.
- Pause keeps the partial second: start_stop, 50 ticks, pause, 200 ticks, start_stop, 50 ticks -> disp=0001 (pause ticks ignored).
- Wrap: load 59:58 by running 3598 s, then 200 ticks -> disp=0000, wrap high for exactly one cycle, counting continues.
- Lap (STOPWATCH_LAP_EN): at 00:05 pulse lap_reset, run 3 s -> disp=0005, state=11. Pulse lap_reset -> disp=0008, state=01.
- Simultaneous/clear: in COUNT, pulse both buttons in one cycle -> PAUSE. Then lap_reset -> IDLE, disp=0000, prescaler=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD time counter.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;
  localparam logic [DIGIT_W-1:0] DIGIT_HI_MAX = 4'd5;

  // True when a (tens, units) digit pair sits at its 59 limit.
  function automatic logic at_59(input logic [DIGIT_W-1:0] hi, input logic [DIGIT_W-1:0] lo);
    return (hi == DIGIT_HI_MAX) && (lo == DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// MM:SS BCD digit chain with carries; clr has priority over inc, wrap pulses after 59:59 -> 00:00.
module bcd_mmss_counter
  import stopwatch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] time_bcd,
  output logic        wrap
);

  logic [DIGIT_W-1:0] sec_lo;
  logic [DIGIT_W-1:0] sec_hi;
  logic [DIGIT_W-1:0] min_lo;
  logic [DIGIT_W-1:0] min_hi;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sec_lo <= '0;
      sec_hi <= '0;
      min_lo <= '0;
      min_hi <= '0;
      wrap   <= 1'b0;
    end else begin
      wrap <= inc && at_59(min_hi, min_lo) && at_59(sec_hi, sec_lo);
      if (inc) begin
        if (sec_lo == DIGIT_MAX) begin
          sec_lo <= '0;
          if (sec_hi == DIGIT_HI_MAX) begin
            sec_hi <= '0;
            if (min_lo == DIGIT_MAX) begin
              min_lo <= '0;
              if (min_hi == DIGIT_HI_MAX) min_hi <= '0;
              else                        min_hi <= min_hi + 4'd1;
            end else begin
              min_lo <= min_lo + 4'd1;
            end
          end else begin
            sec_hi <= sec_hi + 4'd1;
          end
        end else begin
          sec_lo <= sec_lo + 4'd1;
        end
      end
    end
  end

  assign time_bcd = {min_hi, min_lo, sec_hi, sec_lo};

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear FSM, tick prescaler, lap register and display select.
// Optional lap freeze feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned PRESC_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        lap_reset,
  input  logic        tick,
  output logic [1:0]  state,
  output logic        running,
  output logic [15:0] disp,
  output logic        wrap
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

  state_t             state_q;
  logic [PRESC_W-1:0] presc;
  logic [15:0]        live_time;
  logic               active;
  logic               clr_time;
  logic               sec_inc;

  assign active   = (state_q == ST_COUNT) || (state_q == ST_LAP);
  // start_stop wins a same-cycle collision, so a clear needs lap_reset alone.
  assign clr_time = (state_q == ST_PAUSE) && lap_reset && !start_stop;
  assign sec_inc  = active && tick && (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_stop) state_q <= ST_COUNT;
        ST_COUNT: begin
          if (start_stop) state_q <= ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
          else if (lap_reset) state_q <= ST_LAP;
`endif
        end
`ifdef STOPWATCH_LAP_EN
        ST_LAP: begin
          if (start_stop)     state_q <= ST_PAUSE;
          else if (lap_reset) state_q <= ST_COUNT;
        end
`endif
        ST_PAUSE: begin
          if (start_stop)     state_q <= ST_COUNT;
          else if (lap_reset) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_time) begin
      presc <= '0;
    end else if (active && tick) begin
      if (presc == PRESC_LAST) presc <= '0;
      else                     presc <= presc + PRESC_ONE;
    end
  end

  bcd_mmss_counter u_time (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_time),
    .inc      (sec_inc),
    .time_bcd (live_time),
    .wrap     (wrap)
  );

`ifdef STOPWATCH_LAP_EN
  logic [15:0] lap_time;

  // Captures the pre-edge live time, even if a second advances on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_time <= '0;
    end else if ((state_q == ST_COUNT) && lap_reset && !start_stop) begin
      lap_time <= live_time;
    end
  end

  always_comb begin
    disp = live_time;
    if (state_q == ST_LAP) disp = lap_time;
  end
`else
  always_comb begin
    disp = live_time;
  end
`endif

  assign state   = state_q;
  assign running = active;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl, run with a short second (4 ticks).
module tb_stopwatch_ctrl;

  localparam int unsigned TPS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_stop = 1'b0;
  logic        lap_reset = 1'b0;
  logic        tick = 1'b0;
  logic [1:0]  state;
  logic        running;
  logic [15:0] disp;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.TICKS_PER_SEC(TPS), .PRESC_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .lap_reset  (lap_reset),
    .tick       (tick),
    .state      (state),
    .running    (running),
    .disp       (disp),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic ss, input logic lr, input logic tk);
    start_stop = ss;
    lap_reset  = lr;
    tick       = tk;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    lap_reset  = 1'b0;
    tick       = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [1:0] st, input logic run, input logic [15:0] d);
    chk({tag, "_state"}, {14'd0, state}, {14'd0, st});
    chk({tag, "_running"}, {15'd0, running}, {15'd0, run});
    chk({tag, "_disp"}, disp, d);
  endtask

  initial begin
    #1;
    // Reset held two cycles, then lap_reset in IDLE is ignored
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    chk_st("reset", 2'b00, 1'b0, 16'h0000);
    chk("reset_wrap", {15'd0, wrap}, 16'd0);
    ticks(TPS);
    chk("idle_no_count", disp, 16'h0000);

    // Count three seconds; check latency boundary at the last tick
    cyc(1'b1, 1'b0, 1'b0);
    chk_st("count", 2'b01, 1'b1, 16'h0000);
    ticks(3 * TPS - 1);
    chk("count_pre", disp, 16'h0002);
    ticks(1);
    chk("count_3s", disp, 16'h0003);

    // Pause then clear
    cyc(1'b1, 1'b0, 1'b0);
    chk_st("pause", 2'b10, 1'b0, 16'h0003);
    cyc(1'b0, 1'b1, 1'b0);
    chk_st("clear", 2'b00, 1'b0, 16'h0000);

    // Pause keeps the partial second, pause ticks ignored
    cyc(1'b1, 1'b0, 1'b0);
    ticks(2);
    cyc(1'b1, 1'b0, 1'b0);
    ticks(2 * TPS);
    chk_st("pause_hold", 2'b10, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0);
    ticks(1);
    chk("resume_pre", disp, 16'h0000);
    ticks(1);
    chk("resume_1s", disp, 16'h0001);

    // start_stop on a terminal tick: pause and the second still advances
    ticks(TPS - 1);
    cyc(1'b1, 1'b0, 1'b1);
    chk_st("ss_term_tick", 2'b10, 1'b0, 16'h0002);

    // Both buttons in COUNT -> PAUSE; lap_reset clears prescaler and time
    cyc(1'b1, 1'b0, 1'b0);
    ticks(2);
    cyc(1'b1, 1'b1, 1'b0);
    chk("both_btn_state", {14'd0, state}, 16'h0002);
    cyc(1'b0, 1'b1, 1'b0);
    chk_st("clear2", 2'b00, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0);
    ticks(TPS - 1);
    chk("presc_cleared", disp, 16'h0000);
    ticks(1);
    chk("presc_cleared_1s", disp, 16'h0001);

    // Lap freeze / release (or lap_reset ignored when the feature is absent)
    ticks(4 * TPS);
    chk("at_5s", disp, 16'h0005);
`ifdef STOPWATCH_LAP_EN
    cyc(1'b0, 1'b1, 1'b0);
    chk_st("lap_enter", 2'b11, 1'b1, 16'h0005);
    ticks(3 * TPS);
    chk_st("lap_frozen", 2'b11, 1'b1, 16'h0005);
    cyc(1'b0, 1'b1, 1'b0);
    chk_st("lap_release", 2'b01, 1'b1, 16'h0008);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk_st("lap_to_pause", 2'b10, 1'b0, 16'h0008);
`else
    cyc(1'b0, 1'b1, 1'b0);
    chk_st("nolap_ignore", 2'b01, 1'b1, 16'h0005);
    ticks(3 * TPS);
    chk("nolap_live", disp, 16'h0008);
    cyc(1'b1, 1'b0, 1'b0);
    chk_st("nolap_pause", 2'b10, 1'b0, 16'h0008);
`endif
    cyc(1'b0, 1'b1, 1'b0);
    chk_st("clear3", 2'b00, 1'b0, 16'h0000);

    // Long run through minute and ten-minute carries to the wrap
    cyc(1'b1, 1'b0, 1'b0);
    ticks(59 * TPS);
    chk("t_0059", disp, 16'h0059);
    ticks(TPS);
    chk("t_0100", disp, 16'h0100);
    ticks(539 * TPS);
    chk("t_0959", disp, 16'h0959);
    ticks(TPS);
    chk("t_1000", disp, 16'h1000);
    chk("no_wrap_1000", {15'd0, wrap}, 16'd0);
    ticks(2998 * TPS);
    chk("t_5958", disp, 16'h5958);
    ticks(TPS);
    chk("t_5959", disp, 16'h5959);
    ticks(TPS - 1);
    chk("pre_wrap", {15'd0, wrap}, 16'd0);
    ticks(1);
    chk("wrap_disp", disp, 16'h0000);
    chk("wrap_high", {15'd0, wrap}, 16'd1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("wrap_one_cycle", {15'd0, wrap}, 16'd0);
    ticks(TPS);
    chk("after_wrap", disp, 16'h0001);
    chk("after_wrap_state", {14'd0, state}, 16'h0001);

    // Reset mid-count beats simultaneous buttons and a tick
    ticks(TPS - 1);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    chk_st("rst_mid", 2'b00, 1'b0, 16'h0000);
    chk("rst_mid_wrap", {15'd0, wrap}, 16'd0);
    cyc(1'b1, 1'b0, 1'b0);
    ticks(TPS - 1);
    chk("rst_presc", disp, 16'h0000);
    ticks(1);
    chk("rst_presc_1s", disp, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
